maze_rom_arbiter: RTL and testbench

MAZE_ROM_ARBITER -- requirements
Module: maze_rom_arbiter

---
 rtl/maze_rom_arbiter.sv | 113 +++++++++++
 tb/tb_maze_rom_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/maze_rom_arbiter.sv
// maze_rom_arbiter: shares one registered maze ROM port between display fetches
// and a 3x3 collision checker, and switches maze level only at frame end.
module maze_rom_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_req,
    input  logic [12:0] disp_index,
    output logic [15:0] disp_data,
    output logic        disp_valid,
    input  logic        chk_req,
    input  logic [6:0]  chk_x,
    input  logic [5:0]  chk_y,
    output logic        chk_busy,
    output logic        chk_done,
    output logic        chk_wall,
    output logic        chk_goal,
    input  logic        lvl_req,
    input  logic [3:0]  lvl_in,
    output logic [12:0] rom_index,
    output logic [3:0]  rom_sel,
    input  logic [15:0] rom_data
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
    state_t state, state_nxt;
    logic [6:0] cx;
    logic [5:0] cy;
    logic [1:0] dx, dy;
    logic [7:0] px;
    logic [6:0] py;
    logic [12:0] chk_idx;
    logic [15:0] hold;
    logic [3:0] pend_lvl;
    logic disp_tag, chk_tag, oob, chk_issue, step, last, pend_v, last_end, apply, lvl_ok;

    assign px = {1'b0, cx} + {6'd0, dx};
    assign py = {1'b0, cy} + {5'd0, dy};
    assign oob = px > 8'd95 || py > 7'd63;
    assign chk_idx = {6'd0, py} * 13'd96 + {5'd0, px};
    // out-of-bounds offsets advance without a ROM slot; in-bounds ones wait for a free cycle
    assign chk_issue = state == SCAN && !oob && !disp_req;
    assign step = state == SCAN && (oob || !disp_req);
    assign last = dx == 2'd2 && dy == 2'd2;
    assign rom_index = disp_req ? disp_index : chk_issue ? chk_idx : 13'd0;
    assign disp_valid = disp_tag;
    assign disp_data = disp_tag ? rom_data : hold;
    assign chk_busy = state == SCAN || state == DRAIN;
    assign chk_done = state == DONE;
    assign lvl_ok = lvl_req && lvl_in != 4'd0 && lvl_in <= 4'd9;
    assign apply = pend_v && state == IDLE && !disp_tag && !chk_tag && !disp_req && last_end;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = chk_req ? SCAN : IDLE;
            SCAN:  state_nxt = step && last ? DRAIN : SCAN;
            // the final read returns during this cycle and is folded into the flags at its end
            DRAIN: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx <= 7'd0;
            cy <= 6'd0;
            dx <= 2'd0;
            dy <= 2'd0;
            chk_wall <= 1'b0;
            chk_goal <= 1'b0;
            chk_tag <= 1'b0;
            disp_tag <= 1'b0;
            hold <= 16'd0;
            pend_lvl <= 4'd0;
            pend_v <= 1'b0;
            last_end <= 1'b0;
            rom_sel <= 4'd1;
        end else begin
            disp_tag <= disp_req;
            chk_tag <= chk_issue;
            if (disp_tag) hold <= rom_data;
            if (disp_req) last_end <= disp_index == 13'd6143;
            if (state == IDLE && chk_req) begin
                cx <= chk_x;
                cy <= chk_y;
                dx <= 2'd0;
                dy <= 2'd0;
                chk_wall <= 1'b0;
                chk_goal <= 1'b0;
            end else begin
                if (step) begin
                    dx <= dx == 2'd2 ? 2'd0 : dx + 2'd1;
                    dy <= dx == 2'd2 ? dy + 2'd1 : dy;
                end
                if ((step && oob) || (chk_tag && rom_data == 16'hFFFF)) chk_wall <= 1'b1;
                if (chk_tag && rom_data == 16'h001F) chk_goal <= 1'b1;
            end
            if (apply) begin
                rom_sel <= pend_lvl;
                pend_v <= 1'b0;
            end
            if (lvl_ok) begin
                pend_lvl <= lvl_in;
                pend_v <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_maze_rom_arbiter.sv
// tb_maze_rom_arbiter: directed bench with a registered ROM model holding
// a goal block and a wall pixel on level 1.
module tb_maze_rom_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic disp_req, chk_req, lvl_req;
    logic [12:0] disp_index, rom_index;
    logic [15:0] disp_data, rom_data;
    logic disp_valid, chk_busy, chk_done, chk_wall, chk_goal;
    logic [6:0] chk_x;
    logic [5:0] chk_y;
    logic [3:0] lvl_in, rom_sel;
    int checks = 0;
    int errors = 0;
    int exp_open[9] = '{510, 511, 512, 606, 607, 608, 702, 703, 704};

    maze_rom_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_index(disp_index), .disp_data(disp_data), .disp_valid(disp_valid),
        .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_busy(chk_busy), .chk_done(chk_done),
        .chk_wall(chk_wall), .chk_goal(chk_goal), .lvl_req(lvl_req), .lvl_in(lvl_in),
        .rom_index(rom_index), .rom_sel(rom_sel), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [3:0] s, input logic [12:0] i);
        int x, y;
        x = int'(i) % 96;
        y = int'(i) / 96;
        if (s == 4'd1 && x >= 50 && x <= 52 && y >= 20 && y <= 22) return 16'h001F;
        if (s == 4'd1 && x == 40 && y == 40) return 16'hFFFF;
        return {s, i[11:0]};
    endfunction

    always_ff @(posedge clk) rom_data <= rom_word(rom_sel, rom_index);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic probe;
        @(negedge clk);
    endtask

    task automatic run_chk(input string tag, input logic [6:0] x, input logic [5:0] y,
                           input int idx[9], input logic ew, input logic eg);
        int dc;
        dc = 0;
        tick; chk_req = 1; chk_x = x; chk_y = y; disp_req = 0; probe;
        check({tag, "_acc_busy"}, chk_busy, 0);
        for (int c = 1; c <= 20 && dc == 0; c++) begin
            tick; chk_req = (c == 1); chk_x = 0; chk_y = 0; probe;
            if (c <= 9 && idx[c-1] >= 0) check($sformatf("%s_idx%0d", tag, c), rom_index, idx[c-1]);
            if (c == 1) check({tag, "_busy"}, chk_busy, 1);
            if (chk_done) dc = c;
        end
        check({tag, "_done_cyc"}, dc, 11);
        check({tag, "_wall"}, chk_wall, ew);
        check({tag, "_goal"}, chk_goal, eg);
        tick; probe;
        check({tag, "_done_pulse"}, chk_done, 0);
        check({tag, "_idle"}, chk_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int nr, dc, nd;
        logic pd;
        logic [12:0] pidx;
        rst_n = 0; disp_req = 0; disp_index = 0; chk_req = 0; chk_x = 0; chk_y = 0;
        lvl_req = 0; lvl_in = 0;
        #12;
        check("rst_data", disp_data, 0);
        check("rst_valid", disp_valid, 0);
        check("rst_busy", chk_busy, 0);
        check("rst_done", chk_done, 0);
        check("rst_flags", {chk_wall, chk_goal}, 0);
        check("rst_index", rom_index, 0);
        check("rst_sel", rom_sel, 1);
        @(negedge clk) rst_n = 1;

        tick; disp_req = 1; disp_index = 0; probe;
        check("d_idx0", rom_index, 0);
        tick; disp_index = 1; probe;
        check("d_v0", disp_valid, 1); check("d_data0", disp_data, 16'h1000);
        tick; disp_index = 2; probe;
        check("d_v1", disp_valid, 1); check("d_data1", disp_data, 16'h1001);
        tick; disp_req = 0; probe;
        check("d_v2", disp_valid, 1); check("d_data2", disp_data, 16'h1002);
        tick; probe;
        check("d_gap_valid", disp_valid, 0); check("d_hold", disp_data, 16'h1002);

        run_chk("open", 7'd30, 6'd5, exp_open, 0, 0);
        run_chk("edge", 7'd94, 6'd62, '{6046, 6047, -1, 6142, 6143, -1, -1, -1, -1}, 1, 0);
        run_chk("goal", 7'd50, 6'd20, '{1970, 1971, 1972, 2066, 2067, 2068, 2162, 2163, 2164}, 0, 1);
        run_chk("wall", 7'd39, 6'd39, '{3783, 3784, 3785, 3879, 3880, 3881, 3975, 3976, 3977}, 1, 0);

        tick; chk_req = 1; chk_x = 30; chk_y = 5; disp_req = 0; probe;
        nr = 0; dc = 0; pd = 0; pidx = 0;
        for (int c = 1; c <= 30 && dc == 0; c++) begin
            tick; chk_req = 0; disp_req = (c % 2 == 0); disp_index = 13'(200 + c); probe;
            if (pd) begin
                check("ct_valid", disp_valid, 1);
                check("ct_data", disp_data, rom_word(4'd1, pidx));
            end
            if (disp_req) check("ct_didx", rom_index, disp_index);
            else if (nr < 9) begin
                check($sformatf("ct_cidx%0d", nr), rom_index, exp_open[nr]);
                nr++;
            end
            pd = disp_req; pidx = disp_index;
            if (chk_done) dc = c;
        end
        check("ct_done_cyc", dc, 19);
        check("ct_flags", {chk_wall, chk_goal}, 0);
        tick; disp_req = 0; probe;

        tick; lvl_req = 1; lvl_in = 5; disp_req = 1; disp_index = 3000; probe;
        tick; lvl_req = 0; disp_index = 3001; probe;
        check("lv_mid_sel", rom_sel, 1);
        tick; disp_req = 0; probe; tick; probe; tick; probe;
        check("lv_gap_sel", rom_sel, 1);
        tick; disp_req = 1; disp_index = 6143; probe;
        check("lv_end_sel", rom_sel, 1);
        tick; disp_req = 0; probe;
        check("lv_end_data", disp_data, 16'h17FF);
        check("lv_inflight_sel", rom_sel, 1);
        tick; probe;
        check("lv_apply_cyc_sel", rom_sel, 1);
        tick; probe;
        check("lv_new_sel", rom_sel, 5);
        tick; disp_req = 1; disp_index = 7; probe;
        tick; disp_req = 0; probe;
        check("lv_new_data", disp_data, 16'h5007);
        tick; lvl_req = 1; lvl_in = 12; disp_req = 1; disp_index = 6143; probe;
        tick; lvl_req = 0; disp_req = 0; probe;
        repeat (4) begin tick; probe; end
        check("lv_bad_sel", rom_sel, 5);

        tick; lvl_req = 1; lvl_in = 3; chk_req = 1; chk_x = 30; chk_y = 5; probe;
        dc = 0;
        for (int c = 1; c <= 20 && dc == 0; c++) begin
            tick; lvl_req = 0; chk_req = 0; probe;
            if (c == 5) check("sim_busy_sel", rom_sel, 5);
            if (chk_done) dc = c;
        end
        check("sim_done_cyc", dc, 11);
        tick; probe;
        check("sim_wait_sel", rom_sel, 5);
        tick; probe;
        check("sim_new_sel", rom_sel, 3);

        tick; chk_req = 1; chk_x = 30; chk_y = 5; probe;
        tick; chk_req = 0; probe; tick; probe;
        check("rm_busy", chk_busy, 1);
        #1 rst_n = 0;
        #1;
        check("rm_busy_rst", chk_busy, 0);
        check("rm_done_rst", chk_done, 0);
        check("rm_sel_rst", rom_sel, 1);
        check("rm_index_rst", rom_index, 0);
        @(negedge clk) rst_n = 1;
        nd = 0;
        repeat (15) begin
            tick; probe;
            if (chk_done) nd++;
        end
        check("rm_no_done", nd, 0);
        check("rm_idle", chk_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
